mouse_step_gen: RTL
===================

MOUSE_STEP_GEN -- requirements
Module: mouse_step_gen

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning the number of mouse X counts per ship step (legal range 1..64).
REQ-002 The block SHALL have parameter TIMEOUT, default 50000, meaning the number of CLK cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-003 The block SHALL have port CLK, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, synchronous, active-high, sampled on CLK.
REQ-005 The block SHALL have port ps2_clk, input, 1 bit: raw PS/2 mouse clock, asynchronous to CLK.
REQ-006 The block SHALL have port ps2_data, input, 1 bit: raw PS/2 mouse data, asynchronous to CLK.
REQ-007 The block SHALL have port Sm, output, 1 bit: one-cycle pulse requesting a +1 ship step; drives the position counter increment.
REQ-008 The block SHALL have port Rs, output, 1 bit: one-cycle pulse requesting a -1 ship step; drives the position counter decrement.
REQ-009 The block SHALL have port fire, output, 1 bit: left-button level from the last valid packet.
REQ-010 The block SHALL have port pkt_err, output, 1 bit: one-cycle pulse on any discarded byte or packet.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is sync'd clk 1 then 0 on consecutive cycles.
REQ-012 Byte FSM states SHALL be IDLE, DATA, PARITY and STOP; all sampling SHALL occur on a falling edge.
REQ-013 IDLE: data=0 SHALL go to DATA; data=1 SHALL stay in IDLE (spurious start ignored, no pkt_err).
REQ-014 DATA: SHALL shift 8 bits LSB-first and go to PARITY after the 8th bit.
REQ-015 PARITY: SHALL check odd parity over the 8 data bits plus the parity bit, then go to STOP.
REQ-016 STOP: data=1 with good parity SHALL deliver the byte; otherwise the byte SHALL be discarded, pkt_err pulsed and the packet index cleared to 0; in both cases the FSM SHALL return to IDLE.
REQ-017 Outside IDLE, TIMEOUT cycles with no falling edge SHALL force IDLE and clear the packet index; no pkt_err.
REQ-018 Packet index 0..2: byte 0 SHALL be accepted only if bit3=1, otherwise it is discarded with a pkt_err pulse and the index stays 0 (resync).
REQ-019 Byte 0 fields: bit0=left button, bit4=X sign, bit6=X overflow; byte 1 is X magnitude; byte 2 (Y) SHALL be ignored.
REQ-020 On acceptance of byte 2 (packet complete): fire <= left button, and dx = signed 9-bit {sign, byte1}.
REQ-021 If X overflow=1, dx SHALL be treated as 0 and fire SHALL still update.
REQ-022 A signed 12-bit accumulator acc SHALL hold pending counts; at packet complete acc += dx, saturating at +2047/-2048.
REQ-023 Each cycle: if acc >= DIV, Sm SHALL be 1 and acc -= DIV; else if acc <= -DIV, Rs SHALL be 1 and acc += DIV; else both SHALL be 0.
REQ-024 Sm and Rs SHALL never both be high; at most one step SHALL be issued per cycle.
REQ-025 Sm/Rs SHALL be registered; the first step SHALL appear the cycle after the packet-complete cycle.
REQ-026 A packet completing while steps are draining SHALL combine: acc_next = acc + dx -/+ DIV in the same cycle, with no lost counts.
REQ-027 A remainder |acc| < DIV SHALL be retained across packets.

Reset
REQ-028 Rst SHALL set Sm=0, Rs=0, fire=0, pkt_err=0, acc=0, packet index=0, byte FSM=IDLE, timeout counter=0, shift register=0, and synchronizer flops=1 (idle bus).
REQ-029 Rst asserted mid-frame or mid-drain SHALL abandon all pending bytes and steps; no Sm/Rs pulse SHALL occur in the cycle after Rst.

Structure
REQ-030 The byte-FSM state encoding, packet field bit positions (button 0, always-1 3, sign 4, overflow 6) and the accumulator width 12 SHALL live in a shared package, mouse_pkg.
REQ-031 The synchronizer, byte FSM and timeout SHALL be a sub-module ps2_rx_byte (outputs: byte[7:0], byte_vld, byte_err); packet assembly and the step generator SHALL live in the top module.

Verification
REQ-032 Packet 0x09,0x0A,0x00 with DIV=4 -> fire=1; two Sm pulses on consecutive cycles starting one cycle after completion; acc=2 remaining.
REQ-033 Packet 0x18,0xF8,0x00 (dx=-8) from acc=0 -> exactly two Rs pulses, no Sm, acc=0.
REQ-034 Byte with bad parity as byte 1 -> one pkt_err pulse; the next 0x08,0x04,0x00 yields one Sm with no stale data.
REQ-035 Byte 0 = 0x00 (bit3 clear) -> pkt_err, index stays 0; the following valid packet is decoded correctly.
REQ-036 Frame stalled after 4 data bits for TIMEOUT+1 cycles -> FSM in IDLE; a following full packet decodes with no pkt_err.
REQ-037 Rst during a 50-step drain (dx=+200, DIV=4) -> Sm=0 from the next cycle, acc=0, fire=0.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse step generator: byte-receiver states,
// packet header field positions and accumulator sizing.
package mouse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_t;

   localparam int BTN_BIT  = 0;
   localparam int ONE_BIT  = 3;
   localparam int SIGN_BIT = 4;
   localparam int OVF_BIT  = 6;

   localparam int ACC_W   = 12;
   // Two guard bits so a full 9-bit dx can be added before saturating.
   localparam int ACC_EXT = ACC_W + 2;
   localparam logic signed [ACC_EXT-1:0] ACC_MAX = ACC_EXT'(2**(ACC_W-1) - 1);
   localparam logic signed [ACC_EXT-1:0] ACC_MIN = ~ACC_MAX;

   typedef struct packed {
      logic btn;
      logic sign;
      logic ovf;
   } pkt_hdr_t;

   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return (^{data, par}) == 1'b1;
   endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: synchronizes the raw bus, frames start/data/parity/stop
// on ps2_clk falling edges and abandons stalled frames after TIMEOUT cycles.
module ps2_rx_byte
   import mouse_pkg::*;
#(
   parameter int TIMEOUT = 50000
) (
   input  logic       CLK,
   input  logic       Rst,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_vld_o,
   output logic       byte_err_o,
   output logic       tmo_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   logic [1:0]    clk_sync_q;
   logic [1:0]    data_sync_q;
   logic          clk_prev_q;
   rx_state_t     state_q;
   logic [TW-1:0] tmo_cnt_q;
   logic [7:0]    shift_q;
   logic [2:0]    bit_cnt_q;
   logic          par_ok_q;
   logic [7:0]    byte_q;
   logic          vld_q;
   logic          err_q;
   logic          tmo_q;

   logic fall_s;
   logic din_s;

   assign fall_s = clk_prev_q & ~clk_sync_q[1];
   assign din_s  = data_sync_q[1];

   // Synchronizers, frame FSM and stall timeout; strobes are one cycle wide.
   always_ff @(posedge CLK) begin
      if (Rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
         state_q     <= ST_IDLE;
         tmo_cnt_q   <= '0;
         shift_q     <= 8'h00;
         bit_cnt_q   <= 3'd0;
         par_ok_q    <= 1'b0;
         byte_q      <= 8'h00;
         vld_q       <= 1'b0;
         err_q       <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         clk_prev_q  <= clk_sync_q[1];
         vld_q       <= 1'b0;
         err_q       <= 1'b0;
         tmo_q       <= 1'b0;
         if (state_q != ST_IDLE && !fall_s) begin
            if (tmo_cnt_q == TMO_LAST) begin
               state_q   <= ST_IDLE;
               tmo_cnt_q <= '0;
               tmo_q     <= 1'b1;
            end else begin
               tmo_cnt_q <= tmo_cnt_q + {{(TW-1){1'b0}}, 1'b1};
            end
         end else begin
            tmo_cnt_q <= '0;
            case (state_q)
               ST_IDLE: begin
                  if (fall_s && !din_s) begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= 3'd0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_DATA: begin
                  shift_q   <= {din_s, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= ST_PARITY;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
               ST_PARITY: begin
                  par_ok_q <= odd_parity_ok(shift_q, din_s);
                  state_q  <= ST_STOP;
               end
               ST_STOP: begin
                  if (din_s && par_ok_q) begin
                     byte_q <= shift_q;
                     vld_q  <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign byte_o     = byte_q;
   assign byte_vld_o = vld_q;
   assign byte_err_o = err_q;
   assign tmo_o      = tmo_q;

endmodule

// File: rtl/mouse_step_gen.sv
// Turns PS/2 mouse X motion into +1/-1 ship-step pulses (one per DIV counts)
// and tracks the left button as a fire level.
module mouse_step_gen
   import mouse_pkg::*;
#(
   parameter int DIV     = 4,
   parameter int TIMEOUT = 50000
) (
   input  logic CLK,
   input  logic Rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic Sm,
   output logic Rs,
   output logic fire,
   output logic pkt_err
);

   localparam logic signed [ACC_EXT-1:0] DIV_W = ACC_EXT'(DIV);

   logic [7:0] rx_byte_s;
   logic       rx_vld_s;
   logic       rx_err_s;
   logic       rx_tmo_s;

   ps2_rx_byte #(
      .TIMEOUT (TIMEOUT)
   ) u_rx (
      .CLK        (CLK),
      .Rst        (Rst),
      .ps2_clk_i  (ps2_clk),
      .ps2_data_i (ps2_data),
      .byte_o     (rx_byte_s),
      .byte_vld_o (rx_vld_s),
      .byte_err_o (rx_err_s),
      .tmo_o      (rx_tmo_s)
   );

   logic [1:0]               idx_q, idx_d;
   pkt_hdr_t                 hdr_q, hdr_d;
   logic [7:0]               mag_q, mag_d;
   logic                     fire_q, fire_d;
   logic                     err_q, err_d;
   logic                     sm_q, sm_d;
   logic                     rs_q, rs_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;

   logic                     done_s;
   logic signed [8:0]        dx_s;
   logic signed [ACC_EXT-1:0] dx_ext_s;
   logic signed [ACC_EXT-1:0] sum_s;
   logic signed [ACC_EXT-1:0] sat_s;

   // Packet assembly: header resync on bit3, magnitude capture, completion.
   always_comb begin
      idx_d  = idx_q;
      hdr_d  = hdr_q;
      mag_d  = mag_q;
      err_d  = 1'b0;
      done_s = 1'b0;
      if (rx_err_s) begin
         err_d = 1'b1;
         idx_d = 2'd0;
      end else if (rx_tmo_s) begin
         idx_d = 2'd0;
      end else if (rx_vld_s) begin
         case (idx_q)
            2'd0: begin
               if (rx_byte_s[ONE_BIT]) begin
                  hdr_d.btn  = rx_byte_s[BTN_BIT];
                  hdr_d.sign = rx_byte_s[SIGN_BIT];
                  hdr_d.ovf  = rx_byte_s[OVF_BIT];
                  idx_d      = 2'd1;
               end else begin
                  err_d = 1'b1;
               end
            end
            2'd1: begin
               mag_d = rx_byte_s;
               idx_d = 2'd2;
            end
            2'd2: begin
               done_s = 1'b1;
               idx_d  = 2'd0;
            end
            default: begin
               idx_d = 2'd0;
            end
         endcase
      end else begin
         idx_d = idx_q;
      end
   end

   // Accumulate dx with saturation, then issue at most one step per cycle.
   always_comb begin
      if (hdr_q.ovf) begin
         dx_s = 9'sd0;
      end else begin
         dx_s = {hdr_q.sign, mag_q};
      end
      if (done_s) begin
         dx_ext_s = ACC_EXT'(dx_s);
         fire_d   = hdr_q.btn;
      end else begin
         dx_ext_s = '0;
         fire_d   = fire_q;
      end
      sum_s = ACC_EXT'(acc_q) + dx_ext_s;
      if (sum_s > ACC_MAX) begin
         sat_s = ACC_MAX;
      end else if (sum_s < ACC_MIN) begin
         sat_s = ACC_MIN;
      end else begin
         sat_s = sum_s;
      end
      sm_d  = 1'b0;
      rs_d  = 1'b0;
      acc_d = ACC_W'(sat_s);
      if (sat_s >= DIV_W) begin
         sm_d  = 1'b1;
         acc_d = ACC_W'(sat_s - DIV_W);
      end else if (sat_s <= -DIV_W) begin
         rs_d  = 1'b1;
         acc_d = ACC_W'(sat_s + DIV_W);
      end else begin
         acc_d = ACC_W'(sat_s);
      end
   end

   // State and registered outputs.
   always_ff @(posedge CLK) begin
      if (Rst) begin
         idx_q  <= 2'd0;
         hdr_q  <= '0;
         mag_q  <= 8'h00;
         fire_q <= 1'b0;
         err_q  <= 1'b0;
         sm_q   <= 1'b0;
         rs_q   <= 1'b0;
         acc_q  <= '0;
      end else begin
         idx_q  <= idx_d;
         hdr_q  <= hdr_d;
         mag_q  <= mag_d;
         fire_q <= fire_d;
         err_q  <= err_d;
         sm_q   <= sm_d;
         rs_q   <= rs_d;
         acc_q  <= acc_d;
      end
   end

   assign Sm      = sm_q;
   assign Rs      = rs_q;
   assign fire    = fire_q;
   assign pkt_err = err_q;

endmodule
